// File: rtl/vga_board_renderer_if.sv
// vga_board_renderer_if
//   Groups the game-state inputs and the video outputs of the board renderer.
//   GRID_N sets the width of the packed cell-state vector.
//
//   Game side (master drives, slave samples):
//     pos          2*GRID_N*GRID_N  cell states, row-major, cell 0 in the top bits
//     illegal_move 1                illegal move flag
//     no_space     1                board full / draw flag
//     who          2                winner (01 player-1, 10 player-2)
//   Video side (slave drives, master samples):
//     hsync, vsync 1                active-high syncs, aligned with RGB
//     red, green   3                pixel colour
//     blue         2                pixel colour
//     frame_start  1                one-clk pulse when the inputs are latched
//     h_count      16               raw horizontal counter (pre-pipeline)
//     v_count      16               raw vertical counter (pre-pipeline)
interface vga_board_renderer_if #(
  parameter int GRID_N = 3
);
  logic [2*GRID_N*GRID_N-1:0] pos;
  logic                       illegal_move;
  logic                       no_space;
  logic [1:0]                 who;
  logic                       hsync;
  logic                       vsync;
  logic [2:0]                 red;
  logic [2:0]                 green;
  logic [1:0]                 blue;
  logic                       frame_start;
  logic [15:0]                h_count;
  logic [15:0]                v_count;

  modport master (
    output pos, illegal_move, no_space, who,
    input  hsync, vsync, red, green, blue, frame_start, h_count, v_count
  );

  modport slave (
    input  pos, illegal_move, no_space, who,
    output hsync, vsync, red, green, blue, frame_start, h_count, v_count
  );
endinterface

// File: rtl/vga_board_renderer.sv
// vga_board_renderer
//   VGA timing generator and GRID_N x GRID_N board renderer. A pixel-enable
//   divider advances the H/V counters; the game state is copied into shadow
//   registers once per frame (at h=0, v=0) so a frame never shows a partial
//   update. Colour is produced by a two-stage pipeline (region decode, then
//   colour select) and the syncs travel through matching stages, so every
//   output reflects the counter value from two pix_en ticks earlier.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    slave side of vga_board_renderer_if (game inputs, video outputs)
module vga_board_renderer #(
  parameter int GRID_N       = 3,
  parameter int CELL_PIX     = 150,
  parameter int LINE_W       = 3,
  parameter int MARK_INSET   = 15,
  parameter int BOARD_X0     = 8,
  parameter int BOARD_Y0     = 10,
  parameter int PANEL_X0     = 496,
  parameter int PANEL_W      = 120,
  parameter int CLK_DIV      = 2,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 30,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 9,
  parameter int BLINK_FRAMES = 30
) (
  input logic           clk,
  input logic           reset,
  vga_board_renderer_if.slave bus
);

  localparam int NCELL   = GRID_N * GRID_N;
  localparam int PITCH   = CELL_PIX + LINE_W;
  localparam int EXTENT  = GRID_N * PITCH + LINE_W;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0     = H_SYNC + H_BACK;
  localparam int VA0     = V_SYNC + V_BACK;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] HS_END   = 16'(H_SYNC);
  localparam logic [15:0] VS_END   = 16'(V_SYNC);
  localparam logic [15:0] HA_START = 16'(HA0);
  localparam logic [15:0] HA_END   = 16'(HA0 + H_ACTIVE);
  localparam logic [15:0] VA_START = 16'(VA0);
  localparam logic [15:0] VA_END   = 16'(VA0 + V_ACTIVE);
  localparam logic [15:0] BX_START = 16'(HA0 + BOARD_X0);
  localparam logic [15:0] BX_END   = 16'(HA0 + BOARD_X0 + EXTENT);
  localparam logic [15:0] BY_START = 16'(VA0 + BOARD_Y0);
  localparam logic [15:0] BY_END   = 16'(VA0 + BOARD_Y0 + EXTENT);
  localparam logic [15:0] PX_START = 16'(HA0 + PANEL_X0);
  localparam logic [15:0] PX_END   = 16'(HA0 + PANEL_X0 + PANEL_W);
  localparam logic [15:0] OFF_LAST = 16'(PITCH - 1);
  localparam logic [15:0] LINE_END = 16'(LINE_W);
  localparam logic [15:0] MARK_LO  = 16'(LINE_W + MARK_INSET);
  localparam logic [15:0] MARK_HI  = 16'(LINE_W + CELL_PIX - MARK_INSET);
  localparam logic [2:0]  IDX_MAX  = 3'(GRID_N);

  localparam logic [7:0] C_BLACK  = 8'b000_000_00;
  localparam logic [7:0] C_WHITE  = 8'b111_111_11;
  localparam logic [7:0] C_RED    = 8'b111_000_00;
  localparam logic [7:0] C_GREEN  = 8'b000_111_00;
  localparam logic [7:0] C_BLUE   = 8'b000_000_11;
  localparam logic [7:0] C_YELLOW = 8'b111_111_00;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [15:0]        h_q, h_d, v_q, v_d;
  logic [15:0]        cx_off_q, cx_off_d, cy_off_q, cy_off_d;
  logic [2:0]         cx_idx_q, cx_idx_d, cy_idx_q, cy_idx_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [2*NCELL-1:0] pos_s_q, pos_s_d;
  logic               illegal_s_q, illegal_s_d;
  logic               no_space_s_q, no_space_s_d;
  logic [1:0]         who_s_q, who_s_d;
  logic               s1_line_q, s1_line_d, s1_mark_q, s1_mark_d;
  logic               s1_panel_q, s1_panel_d;
  logic [3:0]         s1_cell_q, s1_cell_d;
  logic               s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic [7:0]         rgb_q, rgb_d;
  logic               s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;

  logic       pix_en, line_wrap, frame_end, frame_tick;
  logic       in_active, in_board, in_panel;
  logic [1:0] cell_state;

  assign pix_en     = (div_q == '0);
  assign line_wrap  = pix_en && (h_q == H_LAST);
  assign frame_end  = line_wrap && (v_q == V_LAST);
  // Gated by reset so the pulse never appears while the block is held.
  assign frame_tick = pix_en && (h_q == '0) && (v_q == '0) && !reset;

  // Pixel divider and raster counters.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
  end

  // Cell sub-counters track the pixel the counters will show next: they
  // reload when that pixel is the board edge and roll over at the pitch,
  // saturating the index at the closing line.
  always_comb begin
    cx_off_d = cx_off_q;
    cx_idx_d = cx_idx_q;
    cy_off_d = cy_off_q;
    cy_idx_d = cy_idx_q;
    if (pix_en) begin
      if (h_d == BX_START) begin
        cx_off_d = '0;
        cx_idx_d = '0;
      end else if (cx_off_q == OFF_LAST) begin
        cx_off_d = '0;
        if (cx_idx_q != IDX_MAX) cx_idx_d = cx_idx_q + 3'd1;
      end else begin
        cx_off_d = cx_off_q + 16'd1;
      end
    end
    if (line_wrap) begin
      if (v_d == BY_START) begin
        cy_off_d = '0;
        cy_idx_d = '0;
      end else if (cy_off_q == OFF_LAST) begin
        cy_off_d = '0;
        if (cy_idx_q != IDX_MAX) cy_idx_d = cy_idx_q + 3'd1;
      end else begin
        cy_off_d = cy_off_q + 16'd1;
      end
    end
  end

  // Blink counter advances on the last pixel of each frame, so the first
  // BLINK_FRAMES frames after reset all show phase 0.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Shadow copy of the game state, refreshed only at the frame latch point.
  always_comb begin
    pos_s_d      = pos_s_q;
    illegal_s_d  = illegal_s_q;
    no_space_s_d = no_space_s_q;
    who_s_d      = who_s_q;
    if (frame_tick) begin
      pos_s_d      = bus.pos;
      illegal_s_d  = bus.illegal_move;
      no_space_s_d = bus.no_space;
      who_s_d      = bus.who;
    end
  end

  // Stage 1 decode: which region the current counter value falls in.
  always_comb begin
    in_active  = (h_q >= HA_START) && (h_q < HA_END) && (v_q >= VA_START) && (v_q < VA_END);
    in_board   = in_active && (h_q >= BX_START) && (h_q < BX_END) &&
                 (v_q >= BY_START) && (v_q < BY_END);
    in_panel   = in_active && (h_q >= PX_START) && (h_q < PX_END) &&
                 (v_q >= BY_START) && (v_q < BY_END);
    s1_line_d  = in_board && ((cx_off_q < LINE_END) || (cy_off_q < LINE_END));
    s1_mark_d  = in_board && (cx_off_q >= MARK_LO) && (cx_off_q < MARK_HI) &&
                 (cy_off_q >= MARK_LO) && (cy_off_q < MARK_HI);
    s1_panel_d = in_panel;
    s1_cell_d  = 4'(cy_idx_q) * 4'(GRID_N) + 4'(cx_idx_q);
    s1_hs_d    = (h_q < HS_END);
    s1_vs_d    = (v_q < VS_END);
  end

  // Stage 2 colour: grid lines beat marks, marks beat the panel.
  always_comb begin
    cell_state = 2'b00;
    for (int k = 0; k < NCELL; k++) begin
      if (s1_cell_q == 4'(k)) cell_state = pos_s_q[2*(NCELL-1-k) +: 2];
    end
    rgb_d = C_BLACK;
    if (s1_line_q) begin
      rgb_d = C_WHITE;
    end else if (s1_mark_q) begin
      case (cell_state)
        2'b01:   rgb_d = C_RED;
        2'b10:   rgb_d = C_GREEN;
        default: rgb_d = C_BLACK;
      endcase
    end else if (s1_panel_q) begin
      if (who_s_q == 2'b01)                rgb_d = C_RED;
      else if (who_s_q == 2'b10)           rgb_d = C_GREEN;
      else if (no_space_s_q)               rgb_d = C_YELLOW;
      else if (illegal_s_q && blink_phase_q) rgb_d = C_BLUE;
      else                                 rgb_d = C_BLACK;
    end
    s2_hs_d = s1_hs_q;
    s2_vs_d = s1_vs_q;
  end

  // Free-running divider, counters, blink and shadow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      cx_off_q      <= '0;
      cx_idx_q      <= '0;
      cy_off_q      <= '0;
      cy_idx_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pos_s_q       <= '0;
      illegal_s_q   <= 1'b0;
      no_space_s_q  <= 1'b0;
      who_s_q       <= '0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      cx_off_q      <= cx_off_d;
      cx_idx_q      <= cx_idx_d;
      cy_off_q      <= cy_off_d;
      cy_idx_q      <= cy_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pos_s_q       <= pos_s_d;
      illegal_s_q   <= illegal_s_d;
      no_space_s_q  <= no_space_s_d;
      who_s_q       <= who_s_d;
    end
  end

  // Pipeline stages advance only on pix_en so sync and RGB stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_line_q  <= 1'b0;
      s1_mark_q  <= 1'b0;
      s1_panel_q <= 1'b0;
      s1_cell_q  <= '0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      rgb_q      <= '0;
      s2_hs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
    end else if (pix_en) begin
      s1_line_q  <= s1_line_d;
      s1_mark_q  <= s1_mark_d;
      s1_panel_q <= s1_panel_d;
      s1_cell_q  <= s1_cell_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      rgb_q      <= rgb_d;
      s2_hs_q    <= s2_hs_d;
      s2_vs_q    <= s2_vs_d;
    end
  end

  assign bus.hsync       = s2_hs_q;
  assign bus.vsync       = s2_vs_q;
  assign bus.red         = rgb_q[7:5];
  assign bus.green       = rgb_q[4:2];
  assign bus.blue        = rgb_q[1:0];
  assign bus.frame_start = frame_tick;
  assign bus.h_count     = h_q;
  assign bus.v_count     = v_q;

endmodule

// File: doc/vga_board_renderer.md
# vga_board_renderer

Parametrised VGA timing generator and N×N game-board renderer for the tic-tac-toe display path. It generates its own H/V counters from a pixel-enable divider and latches board and status inputs once per frame, so a frame never shows a half-updated board. It draws an N×N grid with per-cell player marks, plus a status panel with a blinking illegal-move indication. RGB and sync leave through a fixed-latency registered pipeline that keeps them aligned.

## Interface
- GRID_N, 3, cells per board side (2..4)
- CELL_PIX, 150, cell pitch interior width/height in pixels
- LINE_W, 3, grid line thickness in pixels
- MARK_INSET, 15, inset of the filled mark square inside each cell interior
- BOARD_X0, 8, board left edge in active-area x
- BOARD_Y0, 10, board top edge in active-area y
- PANEL_X0, 496, status panel left edge in active-area x
- PANEL_W, 120, status panel width; panel spans the board's vertical extent
- CLK_DIV, 2, clk cycles per pixel (1..8)
- H_SYNC, 96 / H_BACK, 48 / H_ACTIVE, 640 / H_FRONT, 16, horizontal timing in pixels
- V_SYNC, 2 / V_BACK, 30 / V_ACTIVE, 480 / V_FRONT, 9, vertical timing in lines
- BLINK_FRAMES, 30, frames per blink half-period
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pos  in  2*GRID_N*GRID_N  cell states, row-major; cell k=row*GRID_N+col at pos[2*(GRID_N*GRID_N-1-k) +: 2]
- illegal_move  in  1  illegal move flag
- no_space  in  1  board-full / draw flag
- who  in  2  winner (01 player-1, 10 player-2)
- hsync  out  1  active-high horizontal sync, pipeline-aligned
- vsync  out  1  active-high vertical sync, pipeline-aligned
- red  out  3 / green  out  3 / blue  out  2  pixel colour
- frame_start  out  1  one-clk pulse when input latching occurs
- h_count  out  16 / v_count  out  16  raw counters (pre-pipeline)

## Operation
- Pixel enable: a divider counter asserts pix_en one clk in every CLK_DIV. All counters and pipeline stages advance only on pix_en.
- h_count runs 0..H_TOTAL-1 (H_TOTAL = sum of H params). It wraps to 0, and v_count increments at wrap. v_count wraps at V_TOTAL-1.
- hsync is high while h_count < H_SYNC. vsync is high while v_count < V_SYNC.
- Active area: h_count in [H_SYNC+H_BACK, +H_ACTIVE) and v_count in [V_SYNC+V_BACK, +V_ACTIVE). x and y are the offsets into this area.
- Frame latch: at the pix_en where h_count=0 and v_count=0:
  - pos, illegal_move, no_space and who are copied into shadow registers;
  - frame_start pulses for that clk.
  - Rendering uses only the shadow registers.
- Blink: a frame counter counts 0..BLINK_FRAMES-1 and toggles blink_phase on wrap. blink_phase starts at 0.
- Geometry: pitch = CELL_PIX+LINE_W and board extent = GRID_N*pitch+LINE_W.
  - Column and row indices, plus in-pitch offsets, come from incrementing sub-counters (no dividers or multipliers on x/y).
  - They reset at the board left and top edges and roll over at pitch.
- Pixel colour, first match wins:
  1. Inside the board with in-pitch offset < LINE_W (either axis), or on the closing line: white (111,111,11).
  2. Inside a cell interior at offset o-LINE_W within [MARK_INSET, CELL_PIX-MARK_INSET) on both axes: cell state 01 red (111,000,00), 10 green (000,111,00), 00/11 black.
  3. Inside the panel (x in [PANEL_X0, PANEL_X0+PANEL_W), y within the board extent), using this priority:
     - who=01: red; who=10: green;
     - else no_space: yellow (111,111,00);
     - else illegal_move and blink_phase=1: blue (000,000,11);
     - else black.
  4. Everything else, including blanking: black.
- Pipeline: stage 1 registers the sub-counter and region decode; stage 2 registers the colour. hsync and vsync are delayed through matching registers.

## Timing
- Latency: outputs reflect the counter value from exactly 2 pix_en ticks earlier. Sync and RGB stay mutually aligned.
- An input change mid-frame is invisible until the frame after the next latch. Inputs need no synchronous relationship to the frame.
- Reset (synchronous, any time):
  - divider, h_count, v_count, sub-counters, blink counter and blink_phase all go to 0;
  - shadow registers are cleared;
  - hsync, vsync, red, green, blue and frame_start are 0 while reset is high and through pipeline refill.
- After reset release, the first pix_en is on the first clk. The first frame_start occurs on that first tick (h=0, v=0).
- CLK_DIV=1: pix_en is constantly high.

## Test plan
- Timing: CLK_DIV=2, defaults -> frame_start period 2*800*521 clk; hsync high 96 pix_en per line; vsync high 2 lines.
- Cell mark: pos cell 4 (centre) = 01, x=236, y=238 (h_count=380, v_count=270) -> red=111, green=000, blue=00 two pix_en later. Cell 8 = 10 at x=388, y=390 -> green.
- Grid line: x=8..10 on any board row -> white; x=161 (pitch boundary) -> white; x=7 -> black.
- Frame coherence: set cell 0 = 01 mid-frame -> cell 0 stays black until the first frame_start after the change, then red.
- Panel priority: who=10 with no_space=1 and illegal_move=1 -> green. who=00, no_space=0, illegal_move=1 -> blue for 30 frames, black for 30, repeating.
- Reset mid-frame at h_count=400, v_count=200 -> all outputs 0 next clk; counters at 0; blink_phase 0; first frame_start on the first clk after release.
